// File: rtl/vga_mode_control.sv
// Arbitrates which drawing source owns the framebuffer. A mode change blanks all
// sources, waits for vertical blank, has the framebuffer cleared, then holds blank frames.
module vga_mode_control #(
   parameter int NUM_MODES    = 3,
   parameter int MODE_W       = 2,
   parameter int BLANK_FRAMES = 2,
   parameter int DEFAULT_MODE = 0
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [MODE_W-1:0]    iGameMode,
   input  logic                 iFrameTick,
   input  logic                 iClearDone,
   output logic                 oClearReq,
   output logic [NUM_MODES-1:0] oEnable,
   output logic [MODE_W-1:0]    oActiveMode,
   output logic                 oBusy,
   output logic                 oInvalidMode
);

   typedef enum logic [1:0] {
      RUN,
      WAIT_FRAME,
      CLEAR,
      BLANK
   } state_t;

   localparam logic [MODE_W-1:0] DEF_MODE   = MODE_W'(DEFAULT_MODE);
   localparam logic [MODE_W:0]   MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);
   localparam logic [7:0]        BLANK_INIT = 8'(BLANK_FRAMES);

   function automatic logic [NUM_MODES-1:0] oneHot(input logic [MODE_W-1:0] m);
      logic [NUM_MODES-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_MODES; i++) v[i] = (m == MODE_W'(i));
      return v;
   endfunction

   state_t            state, stateNext;
   logic [MODE_W-1:0] target, targetNext, activeNext;
   logic [7:0]        frameCnt, frameCntNext;
   logic              clearReqNext;
   logic              validMode;

   assign validMode = {1'b0, iGameMode} < MODE_LIMIT;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      stateNext    = state;
      targetNext   = target;
      activeNext   = oActiveMode;
      frameCntNext = frameCnt;
      clearReqNext = oClearReq;
      case (state)
         RUN: begin
            if (validMode && iGameMode != oActiveMode) begin
               targetNext = iGameMode;
               stateNext  = WAIT_FRAME;
            end
         end
         WAIT_FRAME: begin
            if (validMode) targetNext = iGameMode;
            if (iFrameTick) begin
               stateNext    = CLEAR;
               clearReqNext = 1'b1;
            end else if (validMode && iGameMode == oActiveMode) begin
               stateNext = RUN;
            end
         end
         CLEAR: begin
            if (validMode) targetNext = iGameMode;
            // A frame tick arriving with the clear-done pulse is not a blank frame.
            if (iClearDone) begin
               clearReqNext = 1'b0;
               frameCntNext = BLANK_INIT;
               stateNext    = BLANK;
            end
         end
         BLANK: begin
            if (validMode) targetNext = iGameMode;
            if (frameCnt == 8'd0 || (iFrameTick && frameCnt == 8'd1)) begin
               frameCntNext = 8'd0;
               activeNext   = targetNext;
               stateNext    = RUN;
            end else if (iFrameTick) begin
               frameCntNext = frameCnt - 8'd1;
            end
         end
         default: stateNext = RUN;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: the output registers sit on the async reset so a reset drops oClearReq at once.
      if (!resetn) begin
         state        <= RUN;
         target       <= DEF_MODE;
         frameCnt     <= 8'd0;
         oActiveMode  <= DEF_MODE;
         oEnable      <= oneHot(DEF_MODE);
         oClearReq    <= 1'b0;
         oBusy        <= 1'b0;
         oInvalidMode <= 1'b0;
      end else begin
         state        <= stateNext;
         target       <= targetNext;
         frameCnt     <= frameCntNext;
         oActiveMode  <= activeNext;
         oEnable      <= (stateNext == RUN) ? oneHot(activeNext) : '0;
         oClearReq    <= clearReqNext;
         oBusy        <= (stateNext != RUN);
         oInvalidMode <= (state == RUN) && !validMode;
      end
   end

endmodule

// File: tb/tb_vga_mode_control.sv
// Directed bench for vga_mode_control: a phase-level model is compared every cycle,
// and literal expectations at key points pin the model itself.
module tb_vga_mode_control;

   localparam int NMODES = 3;
   localparam int BLANKS = 2;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] gameMode = 2'd0;
   logic       frameTick = 1'b0;
   logic       clearDone = 1'b0;
   logic       clearReq;
   logic [2:0] enable;
   logic [1:0] activeMode;
   logic       busy;
   logic       invalidMode;

   int checks = 0;
   int errors = 0;

   vga_mode_control #(
      .NUM_MODES(NMODES), .MODE_W(2), .BLANK_FRAMES(BLANKS), .DEFAULT_MODE(0)
   ) dut (
      .clk(clk), .resetn(resetn), .iGameMode(gameMode), .iFrameTick(frameTick),
      .iClearDone(clearDone), .oClearReq(clearReq), .oEnable(enable),
      .oActiveMode(activeMode), .oBusy(busy), .oInvalidMode(invalidMode)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: which mode is shown, which is wanted, and where the switch sequence stands.
   typedef enum {M_SHOW, M_ARMED, M_WIPE, M_HOLD} phase_t;
   phase_t mPhase;
   int     mShown, mWanted, mHold;
   bit     mInv;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mPhase  <= M_SHOW;
         mShown  <= 0;
         mWanted <= 0;
         mHold   <= 0;
         mInv    <= 1'b0;
      end else begin
         mInv <= (mPhase == M_SHOW) && (int'(gameMode) >= NMODES);
         if (mPhase != M_SHOW && int'(gameMode) < NMODES) mWanted <= int'(gameMode);
         case (mPhase)
            M_SHOW:
               if (int'(gameMode) < NMODES && int'(gameMode) != mShown) begin
                  mWanted <= int'(gameMode);
                  mPhase  <= M_ARMED;
               end
            M_ARMED:
               if (frameTick) mPhase <= M_WIPE;
               else if (int'(gameMode) == mShown) mPhase <= M_SHOW;
            M_WIPE:
               if (clearDone) begin
                  mHold  <= BLANKS;
                  mPhase <= M_HOLD;
               end
            M_HOLD:
               if (mHold == 0 || (frameTick && mHold == 1)) begin
                  mShown <= (int'(gameMode) < NMODES) ? int'(gameMode) : mWanted;
                  mHold  <= 0;
                  mPhase <= M_SHOW;
               end else if (frameTick) begin
                  mHold <= mHold - 1;
               end
         endcase
      end
   end

   always @(negedge clk) begin
      check("enable", enable, (mPhase == M_SHOW) ? (32'd1 << mShown) : 32'd0);
      check("clearReq", clearReq, (mPhase == M_WIPE) ? 32'd1 : 32'd0);
      check("activeMode", activeMode, mShown);
      check("busy", busy, (mPhase != M_SHOW) ? 32'd1 : 32'd0);
      check("invalidMode", invalidMode, mInv ? 32'd1 : 32'd0);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseTick();
      frameTick = 1'b1;
      @(negedge clk);
      frameTick = 1'b0;
   endtask

   task automatic pulseDone(input bit withTick);
      clearDone = 1'b1;
      frameTick = withTick;
      @(negedge clk);
      clearDone = 1'b0;
      frameTick = 1'b0;
   endtask

   initial begin
      cycles(2);
      check("lit reset enable", enable, 3'b001);
      check("lit reset clearReq", clearReq, 1'b0);
      check("lit reset busy", busy, 1'b0);
      resetn = 1'b1;

      // Idle in default mode.
      cycles(6);
      check("lit idle enable", enable, 3'b001);
      check("lit idle active", activeMode, 2'd0);
      check("lit idle busy", busy, 1'b0);

      // Invalid request: one pulse per sample, enables untouched.
      gameMode = 2'd3;
      cycles(1);
      gameMode = 2'd0;
      check("lit invalid pulse", invalidMode, 1'b1);
      check("lit invalid enable", enable, 3'b001);
      cycles(1);
      check("lit invalid drop", invalidMode, 1'b0);
      gameMode = 2'd3;
      cycles(3);
      gameMode = 2'd0;
      cycles(2);

      // Change then cancel before any frame tick.
      gameMode = 2'd2;
      cycles(1);
      check("lit cancel blanked", enable, 3'b000);
      gameMode = 2'd0;
      cycles(1);
      check("lit cancel restored", enable, 3'b001);
      check("lit cancel noclear", clearReq, 1'b0);
      cycles(2);

      // Full switch 0 -> 1.
      gameMode = 2'd1;
      cycles(1);
      check("lit switch blanked", enable, 3'b000);
      check("lit switch busy", busy, 1'b1);
      cycles(2);
      pulseTick();
      check("lit clearReq high", clearReq, 1'b1);
      cycles(4);
      pulseDone(1'b0);
      check("lit clearReq low", clearReq, 1'b0);
      pulseTick();
      check("lit still blank", enable, 3'b000);
      cycles(2);
      pulseTick();
      check("lit switch enable", enable, 3'b010);
      check("lit switch active", activeMode, 2'd1);
      check("lit switch idle", busy, 1'b0);

      // Stray clear-done in RUN is ignored.
      pulseDone(1'b0);
      cycles(1);
      check("lit stray done", busy, 1'b0);

      // Switch 1 -> 0, retarget to 2 during BLANK; tick with done does not count.
      gameMode = 2'd0;
      cycles(2);
      pulseTick();
      cycles(3);
      pulseDone(1'b1);
      gameMode = 2'd2;
      cycles(2);
      pulseTick();
      check("lit retarget busy", busy, 1'b1);
      pulseTick();
      check("lit retarget enable", enable, 3'b100);
      check("lit retarget active", activeMode, 2'd2);
      cycles(3);

      // Switch 2 -> 1, then back to 2 mid-clear; invalid input ignored off RUN.
      gameMode = 2'd1;
      cycles(1);
      pulseTick();
      gameMode = 2'd2;
      cycles(1);
      gameMode = 2'd3;
      cycles(1);
      check("lit no invalid in clear", invalidMode, 1'b0);
      gameMode = 2'd2;
      pulseDone(1'b0);
      check("lit same target busy", busy, 1'b1);
      pulseTick();
      pulseTick();
      check("lit same target enable", enable, 3'b100);
      check("lit same target idle", busy, 1'b0);
      cycles(2);

      // Reset in the middle of a clear.
      gameMode = 2'd1;
      cycles(1);
      pulseTick();
      cycles(1);
      check("lit pre-reset clearReq", clearReq, 1'b1);
      #2 resetn = 1'b0;
      #1;
      check("lit async clearReq", clearReq, 1'b0);
      check("lit async enable", enable, 3'b001);
      gameMode = 2'd0;
      @(negedge clk);
      resetn = 1'b1;
      cycles(1);
      pulseDone(1'b0);
      cycles(2);
      check("lit late done enable", enable, 3'b001);
      check("lit late done clearReq", clearReq, 1'b0);
      check("lit late done busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
